tile_fetch_agu: RTL

Parametrised tile fetch address generator that walks a 2-D tile in a single-port BRAM and issues one read per element. A descriptor handshake selects base, extent, stride and traversal order (row-major or transposed), so any buffer region (W/b/I/Q/K/V) can be fetched without per-buffer hard-coding. The block honours downstream backpressure and tracks BRAM read latency, tagging returned data with valid/last. It sits between the arbiter control FSM and the BRAM read port, and feeds the systolic-array load path.

---
 rtl/tile_fetch_agu.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tile_fetch_agu.sv
// tile_fetch_agu: 2-D tile walker issuing one BRAM read per element.
// Optional bounds checking is enabled by defining TILE_FETCH_AGU_BOUNDS_CHECK_EN.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req_valid/ready   descriptor handshake (ready only in IDLE)
//   cfg_base/rows/cols/stride/transpose  tile descriptor
//   abort             synchronous cancel of the current tile
//   rd_ready          downstream accepts a read this cycle
//   bram_addr/en      BRAM read port
//   rd_valid/last     read data qualifiers, READ_LATENCY after issue
//   busy              high in ISSUE or DRAIN
//   fetch_done        one-cycle pulse at tile completion
//   addr_err          sticky bounds error (bounds-check build only)
module tile_fetch_agu #(
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH = 10,
  parameter int READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic                  cfg_transpose,
  input  logic                  abort,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  busy,
`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
  output logic                  addr_err,
`endif
  output logic                  fetch_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [1:0]              w_state_n;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_stride;
  logic [ADDR_WIDTH-1:0]   r_row_base;
  logic [DIM_WIDTH-1:0]    r_rows;
  logic [DIM_WIDTH-1:0]    r_cols;
  logic [DIM_WIDTH-1:0]    r_r;
  logic [DIM_WIDTH-1:0]    r_c;
  logic                    r_tr;
  logic [READ_LATENCY-1:0] r_pv;
  logic [READ_LATENCY-1:0] r_pl;
  logic [READ_LATENCY:0]   w_pv_n;
  logic [READ_LATENCY:0]   w_pl_n;
  logic [ADDR_WIDTH:0]     w_rb_sum;
  logic [ADDR_WIDTH:0]     w_addr_sum;
  logic                    w_accept;
  logic                    w_zero;
  logic                    w_last_r;
  logic                    w_last_c;
  logic                    w_last;
  logic                    w_err;
  logic                    w_kill;
  logic                    w_en;
  logic                    w_unused;

  // Carry bits feed the overflow check of the bounds build.
  assign w_rb_sum   = {1'b0, r_row_base} + {1'b0, r_stride};
  assign w_addr_sum = {1'b0, r_row_base} + (ADDR_WIDTH+1)'(r_c);

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_zero   = (cfg_rows == '0) || (cfg_cols == '0);
  assign w_last_r = (r_r == r_rows - DIM_WIDTH'(1));
  assign w_last_c = (r_c == r_cols - DIM_WIDTH'(1));
  assign w_last   = w_last_r && w_last_c;

`ifdef TILE_FETCH_AGU_BOUNDS_CHECK_EN
  logic r_rb_ovf;

  assign w_err = (r_state == S_ISSUE) &&
                 (r_rb_ovf || w_addr_sum[ADDR_WIDTH] ||
                  (w_addr_sum[ADDR_WIDTH-1:0] > ADDR_LIMIT));

  // Sticky flag: the row accumulator has wrapped past the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rb_ovf <= 1'b0;
    end else if (w_accept) begin
      r_rb_ovf <= 1'b0;
    end else if (w_en) begin
      if (!r_tr && w_last_c) begin
        r_rb_ovf <= r_rb_ovf | w_rb_sum[ADDR_WIDTH];
      end else if (r_tr && !w_last_r) begin
        r_rb_ovf <= r_rb_ovf | w_rb_sum[ADDR_WIDTH];
      end else if (r_tr) begin
        r_rb_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if (w_accept) begin
      addr_err <= 1'b0;
    end else if (w_err) begin
      addr_err <= 1'b1;
    end
  end

  assign w_unused = ^{w_pv_n[READ_LATENCY], w_pl_n[READ_LATENCY]};
`else
  assign w_err    = 1'b0;
  assign w_unused = ^{ADDR_LIMIT, w_addr_sum[ADDR_WIDTH],
                      w_rb_sum[ADDR_WIDTH],
                      w_pv_n[READ_LATENCY], w_pl_n[READ_LATENCY]};
`endif

  // Abort (or a bounds error) wins over everything outside IDLE.
  assign w_kill = (r_state != S_IDLE) && (abort || w_err);
  assign w_en   = (r_state == S_ISSUE) && rd_ready && !w_kill;

  assign w_pv_n = {r_pv, w_en};
  assign w_pl_n = {r_pl, w_en && w_last};

  always_comb begin
    w_state_n = r_state;
    if (w_kill) begin
      w_state_n = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            w_state_n = w_zero ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_en && w_last) begin
            w_state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave once nothing remains in flight after this shift.
          if (w_pv_n[READ_LATENCY-1:0] == '0) begin
            w_state_n = S_DONE;
          end
        end
        S_DONE: begin
          w_state_n = S_IDLE;
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_stride   <= '0;
      r_rows     <= '0;
      r_cols     <= '0;
      r_tr       <= 1'b0;
      r_r        <= '0;
      r_c        <= '0;
      r_row_base <= '0;
    end else if (w_accept) begin
      r_base     <= cfg_base;
      r_stride   <= cfg_stride;
      r_rows     <= cfg_rows;
      r_cols     <= cfg_cols;
      r_tr       <= cfg_transpose;
      r_r        <= '0;
      r_c        <= '0;
      r_row_base <= cfg_base;
    end else if (w_en) begin
      if (!r_tr) begin
        if (w_last_c) begin
          r_c        <= '0;
          r_r        <= r_r + DIM_WIDTH'(1);
          r_row_base <= w_rb_sum[ADDR_WIDTH-1:0];
        end else begin
          r_c <= r_c + DIM_WIDTH'(1);
        end
      end else begin
        if (w_last_r) begin
          r_r        <= '0;
          r_c        <= r_c + DIM_WIDTH'(1);
          r_row_base <= r_base;
        end else begin
          r_r        <= r_r + DIM_WIDTH'(1);
          r_row_base <= w_rb_sum[ADDR_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      r_pl <= '0;
    end else if (w_kill) begin
      r_pv <= '0;
      r_pl <= '0;
    end else begin
      r_pv <= w_pv_n[READ_LATENCY-1:0];
      r_pl <= w_pl_n[READ_LATENCY-1:0];
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign fetch_done = (r_state == S_DONE) && !abort;
  assign bram_en    = w_en;
  assign bram_addr  = w_addr_sum[ADDR_WIDTH-1:0];
  assign rd_valid   = r_pv[READ_LATENCY-1];
  assign rd_last    = r_pl[READ_LATENCY-1];

endmodule
